// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the pipeline memory ports, the arbiter and the
// SRAM-like bus slave. The master modport is the arbiter's view. The slave
// modport is the view of everything around it: the two requesters and the
// bus slave.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port (read only)
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic [DATA_W-1:0]     inst_rdata;
    logic                  inst_ok;

    // Data-memory port (read/write)
    logic                  data_req;
    logic                  data_wr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic [DATA_W-1:0]     data_rdata;
    logic                  data_ok;

    // Shared memory bus
    logic                  bus_req;
    logic                  bus_wr;
    logic [DATA_W/8-1:0]   bus_wstrb;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_addr_ok;
    logic                  bus_data_ok;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        input  inst_req, inst_addr,
        output inst_rdata, inst_ok,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_rdata, data_ok,
        output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_rdata, inst_ok,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_rdata, data_ok,
        input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single SRAM-like memory bus between the instruction-fetch
// port and the data port. Each access runs through an address phase and a
// data phase. The data port has priority, and a streak counter stops it
// from starving instruction fetch. Also produces the pipeline stall signals.
module mem_bus_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_bus_arbiter_if.master     bus_if,
    output logic                  if_stall_o,
    output logic                  mem_stall_o
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    // Grant encoding: 0 = instruction port, 1 = data port
    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;

    // Stall controller inputs: a port is stalled while it is requesting and
    // has not yet completed.
    assign if_stall_o  = bus_if.inst_req & ~bus_if.inst_ok;
    assign mem_stall_o = bus_if.data_req & ~bus_if.data_ok;

    // State, grant and streak registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= GNT_INST;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            streak_q <= streak_d;
        end
    end

    // Arbitration, phase sequencing, bus drive and completion routing
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d           = state_q;
        grant_d           = grant_q;
        streak_d          = streak_q;
        bus_if.bus_req    = 1'b0;
        bus_if.bus_wr     = 1'b0;
        bus_if.bus_wstrb  = {STRB_W{1'b0}};
        bus_if.bus_addr   = {ADDR_W{1'b0}};
        bus_if.bus_wdata  = {DATA_W{1'b0}};
        bus_if.inst_ok    = 1'b0;
        bus_if.inst_rdata = {DATA_W{1'b0}};
        bus_if.data_ok    = 1'b0;
        bus_if.data_rdata = {DATA_W{1'b0}};

        // While reset is asserted all outputs stay at their defaults, even
        // if the registered state still points into a transaction.
        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (bus_if.data_req && (!bus_if.inst_req || (streak_q < STREAK_MAX))) begin
                        grant_d = GNT_DATA;
                        state_d = ADDR;
                        // Only count grants that actually made a fetch wait
                        if (bus_if.inst_req) begin
                            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
                        end else begin
                            streak_d = '0;
                        end
                    end else if (bus_if.inst_req) begin
                        grant_d  = GNT_INST;
                        state_d  = ADDR;
                        streak_d = '0;
                    end
                end

                ADDR: begin
                    bus_if.bus_req = 1'b1;
                    if (grant_q == GNT_DATA) begin
                        bus_if.bus_wr    = bus_if.data_wr;
                        bus_if.bus_wstrb = bus_if.data_wr ? bus_if.data_wstrb : {STRB_W{1'b0}};
                        bus_if.bus_addr  = bus_if.data_addr;
                        bus_if.bus_wdata = bus_if.data_wdata;
                    end else begin
                        bus_if.bus_addr  = bus_if.inst_addr;
                    end
                    if (bus_if.bus_addr_ok) begin
                        state_d = DATA;
                    end
                end

                DATA: begin
                    if (bus_if.bus_data_ok) begin
                        state_d = IDLE;
                        if (grant_q == GNT_DATA) begin
                            bus_if.data_ok    = 1'b1;
                            bus_if.data_rdata = bus_if.bus_rdata;
                        end else begin
                            bus_if.inst_ok    = 1'b1;
                            bus_if.inst_rdata = bus_if.bus_rdata;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by a
// randomized run against a word-level memory model and a cycle-driven
// bus slave.
module tb_mem_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAXS   = 4;

    logic clk;
    logic rst;
    logic if_stall_o;
    logic mem_stall_o;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_STREAK(MAXS)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_if      (mif.master),
        .if_stall_o  (if_stall_o),
        .mem_stall_o (mem_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mif.inst_req = 0; mif.inst_addr = '0;
        mif.data_req = 0; mif.data_wr = 0; mif.data_wstrb = '0; mif.data_addr = '0; mif.data_wdata = '0;
        mif.bus_addr_ok = 0; mif.bus_data_ok = 0; mif.bus_rdata = '0;
    endtask

    // One minimal-latency transaction: IDLE, ADDR with addr_ok, DATA with data_ok.
    task automatic run_txn(input logic [DATA_W-1:0] rdata, output logic got_i, output logic got_d);
        mif.bus_addr_ok = 0; mif.bus_data_ok = 0;
        @(negedge clk);
        n_checks++; if (mif.bus_req !== 1'b0) begin n_fail++; $display("FAIL txn_idle_bus_req: got %b want 0", mif.bus_req); end
        tick();
        mif.bus_addr_ok = 1;
        @(negedge clk);
        n_checks++; if (mif.bus_req !== 1'b1) begin n_fail++; $display("FAIL txn_addr_bus_req: got %b want 1", mif.bus_req); end
        tick();
        mif.bus_addr_ok = 0; mif.bus_data_ok = 1; mif.bus_rdata = rdata;
        @(negedge clk);
        got_i = mif.inst_ok; got_d = mif.data_ok;
        tick();
        mif.bus_data_ok = 0; mif.bus_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 0;
        mif.inst_req = 1; mif.inst_addr = 32'h40; mif.data_req = 1; mif.data_wr = 1; mif.data_wstrb = 4'hF;
        mif.bus_addr_ok = 1; mif.bus_data_ok = 1; mif.bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_checks++; if (mif.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b want 0", mif.bus_req); end
        n_checks++; if (mif.bus_addr !== '0) begin n_fail++; $display("FAIL reset_bus_addr: got %h want 0", mif.bus_addr); end
        n_checks++; if ({mif.inst_ok, mif.data_ok} !== 2'b00) begin n_fail++; $display("FAIL reset_ok: got %b want 00", {mif.inst_ok, mif.data_ok}); end
        n_checks++; if ({if_stall_o, mem_stall_o} !== 2'b11) begin n_fail++; $display("FAIL reset_stalls: got %b want 11", {if_stall_o, mem_stall_o}); end
        tick();
        n_checks++; if (dut.streak_q !== '0) begin n_fail++; $display("FAIL reset_streak: got %0d want 0", dut.streak_q); end
        clear_inputs();
        rst = 1;
        tick();
    endtask

    task automatic test_inst_read();
        mif.inst_req = 1; mif.inst_addr = 32'h0000_0100;
        @(negedge clk);
        n_checks++; if (if_stall_o !== 1'b1) begin n_fail++; $display("FAIL inst_stall_c0: got %b want 1", if_stall_o); end
        tick();
        mif.bus_addr_ok = 1;
        @(negedge clk);
        n_checks++; if ({mif.bus_req, mif.bus_wr, mif.bus_wstrb} !== 6'b100000) begin n_fail++; $display("FAIL inst_addr_phase: got %b want 100000", {mif.bus_req, mif.bus_wr, mif.bus_wstrb}); end
        n_checks++; if (mif.bus_addr !== 32'h100) begin n_fail++; $display("FAIL inst_bus_addr: got %h want 00000100", mif.bus_addr); end
        n_checks++; if (if_stall_o !== 1'b1) begin n_fail++; $display("FAIL inst_stall_c1: got %b want 1", if_stall_o); end
        tick();
        mif.bus_addr_ok = 0; mif.bus_data_ok = 1; mif.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if ({mif.inst_ok, mif.data_ok} !== 2'b10) begin n_fail++; $display("FAIL inst_ok_c2: got %b want 10", {mif.inst_ok, mif.data_ok}); end
        n_checks++; if (mif.inst_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL inst_rdata: got %h want deadbeef", mif.inst_rdata); end
        n_checks++; if (if_stall_o !== 1'b0) begin n_fail++; $display("FAIL inst_stall_c2: got %b want 0", if_stall_o); end
        tick();
        clear_inputs();
        @(negedge clk);
        n_checks++; if ({mif.inst_ok, mif.inst_rdata} !== '0) begin n_fail++; $display("FAIL inst_ok_after: got %b/%h want 0/0", mif.inst_ok, mif.inst_rdata); end
        tick();
    endtask

    task automatic test_data_write();
        mif.data_req = 1; mif.data_wr = 1; mif.data_wstrb = 4'b0011; mif.data_addr = 32'h80; mif.data_wdata = 32'h1234_5678;
        @(negedge clk);
        n_checks++; if (mem_stall_o !== 1'b1) begin n_fail++; $display("FAIL wr_stall_c0: got %b want 1", mem_stall_o); end
        tick();
        for (int c = 0; c < 4; c++) begin
            mif.bus_addr_ok = (c == 3);
            @(negedge clk);
            n_checks++;
            if ({mif.bus_req, mif.bus_wr, mif.bus_wstrb, mif.bus_addr, mif.bus_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h80, 32'h1234_5678}) begin
                n_fail++; $display("FAIL wr_addr_phase_%0d: got req=%b wr=%b strb=%b addr=%h wdata=%h want 1 1 0011 00000080 12345678",
                    c, mif.bus_req, mif.bus_wr, mif.bus_wstrb, mif.bus_addr, mif.bus_wdata);
            end
            tick();
        end
        mif.bus_addr_ok = 0; mif.bus_data_ok = 1;
        @(negedge clk);
        n_checks++; if ({mif.data_ok, mif.inst_ok, mif.bus_req, mem_stall_o} !== 4'b1000) begin n_fail++; $display("FAIL wr_complete: got ok/iok/req/stall=%b want 1000", {mif.data_ok, mif.inst_ok, mif.bus_req, mem_stall_o}); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_simultaneous();
        mif.inst_req = 1; mif.inst_addr = 32'h200;
        mif.data_req = 1; mif.data_wr = 0; mif.data_wstrb = 4'hF; mif.data_addr = 32'h40;
        @(negedge clk);
        tick();
        mif.bus_addr_ok = 1;
        @(negedge clk);
        n_checks++; if ({mif.bus_addr, mif.bus_wr, mif.bus_wstrb} !== {32'h40, 1'b0, 4'b0000}) begin n_fail++; $display("FAIL sim_first_grant: got addr=%h wr=%b strb=%b want 00000040 0 0000", mif.bus_addr, mif.bus_wr, mif.bus_wstrb); end
        tick();
        mif.bus_addr_ok = 0; mif.bus_data_ok = 1; mif.bus_rdata = 32'hA5A5_0001;
        @(negedge clk);
        n_checks++; if ({mif.data_ok, mif.inst_ok, mem_stall_o, if_stall_o} !== 4'b1001) begin n_fail++; $display("FAIL sim_data_done: got dok/iok/mstall/istall=%b want 1001", {mif.data_ok, mif.inst_ok, mem_stall_o, if_stall_o}); end
        n_checks++; if (mif.data_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL sim_data_rdata: got %h want a5a50001", mif.data_rdata); end
        tick();
        mif.data_req = 0; mif.bus_data_ok = 0;
        @(negedge clk);
        n_checks++; if ({mif.bus_req, if_stall_o} !== 2'b01) begin n_fail++; $display("FAIL sim_idle2: got req/istall=%b want 01", {mif.bus_req, if_stall_o}); end
        tick();
        mif.bus_addr_ok = 1;
        @(negedge clk);
        n_checks++; if (mif.bus_addr !== 32'h200) begin n_fail++; $display("FAIL sim_second_grant: got %h want 00000200", mif.bus_addr); end
        tick();
        mif.bus_addr_ok = 0; mif.bus_data_ok = 1; mif.bus_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        n_checks++; if ({mif.inst_ok, mif.inst_rdata} !== {1'b1, 32'h0BAD_F00D}) begin n_fail++; $display("FAIL sim_inst_done: got %b/%h want 1/0badf00d", mif.inst_ok, mif.inst_rdata); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_starvation();
        logic gi, gd;
        mif.inst_req = 1; mif.inst_addr = 32'h300;
        mif.data_req = 1; mif.data_wr = 0; mif.data_addr = 32'h44;
        for (int k = 0; k <= MAXS; k++) begin
            run_txn(32'h1000 + k, gi, gd);
            n_checks++;
            if ({gi, gd} !== ((k < MAXS) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL starve_txn_%0d: got inst/data ok=%b want %b", k, {gi, gd}, (k < MAXS) ? 2'b01 : 2'b10);
            end
        end
        clear_inputs();
        n_checks++; if (dut.streak_q !== '0) begin n_fail++; $display("FAIL starve_streak_after: got %0d want 0", dut.streak_q); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic gi, gd;
        mif.data_req = 1; mif.data_wr = 0; mif.data_addr = 32'h48;
        @(negedge clk);
        tick();
        mif.bus_addr_ok = 1;
        @(negedge clk);
        tick();
        mif.bus_addr_ok = 0; rst = 0;
        @(negedge clk);
        n_checks++; if ({mif.bus_req, mif.data_ok, mem_stall_o} !== 3'b001) begin n_fail++; $display("FAIL rstmid_during: got req/ok/stall=%b want 001", {mif.bus_req, mif.data_ok, mem_stall_o}); end
        tick();
        rst = 1; mif.data_req = 0; mif.bus_data_ok = 1; mif.bus_rdata = 32'h1;
        @(negedge clk);
        n_checks++; if ({mif.bus_req, mif.data_ok, mif.inst_ok} !== 3'b000) begin n_fail++; $display("FAIL rstmid_after: got req/dok/iok=%b want 000", {mif.bus_req, mif.data_ok, mif.inst_ok}); end
        tick();
        mif.bus_data_ok = 0; mif.bus_rdata = '0;
        mif.inst_req = 1; mif.inst_addr = 32'h3C;
        run_txn(32'hCAFE_0001, gi, gd);
        n_checks++; if ({gi, gd} !== 2'b10) begin n_fail++; $display("FAIL rstmid_inst_txn: got inst/data ok=%b want 10", {gi, gd}); end
        clear_inputs();
        tick();
    endtask

    task automatic test_spurious();
        mif.bus_addr_ok = 1; mif.bus_data_ok = 1; mif.bus_rdata = 32'h7777_7777;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if ({mif.bus_req, mif.inst_ok, mif.data_ok} !== 3'b000) begin n_fail++; $display("FAIL spur_idle_%0d: got req/iok/dok=%b want 000", c, {mif.bus_req, mif.inst_ok, mif.data_ok}); end
            tick();
        end
        mif.bus_addr_ok = 0; mif.inst_req = 1; mif.inst_addr = 32'h10;
        @(negedge clk);
        n_checks++; if ({mif.bus_req, mif.inst_ok} !== 2'b00) begin n_fail++; $display("FAIL spur_idle_req: got req/iok=%b want 00", {mif.bus_req, mif.inst_ok}); end
        tick();
        @(negedge clk);
        n_checks++; if ({mif.bus_req, mif.inst_ok} !== 2'b10) begin n_fail++; $display("FAIL spur_addr: got req/iok=%b want 10", {mif.bus_req, mif.inst_ok}); end
        tick();
        mif.bus_addr_ok = 1; mif.bus_data_ok = 0;
        @(negedge clk);
        n_checks++; if ({mif.bus_req, mif.inst_ok} !== 2'b10) begin n_fail++; $display("FAIL spur_addr_hold: got req/iok=%b want 10", {mif.bus_req, mif.inst_ok}); end
        tick();
        mif.bus_addr_ok = 0; mif.bus_data_ok = 1; mif.bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        n_checks++; if ({mif.inst_ok, mif.inst_rdata} !== {1'b1, 32'h5555_AAAA}) begin n_fail++; $display("FAIL spur_complete: got %b/%h want 1/5555aaaa", mif.inst_ok, mif.inst_rdata); end
        tick();
        clear_inputs();
        tick();
    endtask

    // Random traffic: both requesters issue accesses to a 16-word memory, the
    // slave answers with random delays and spurious handshakes. Every read
    // must return what the word-level reference memory holds after all
    // earlier completions.
    task automatic test_random(input int n_cycles);
        logic [DATA_W-1:0] ref_mem [16];
        logic [DATA_W-1:0] slv_mem [16];
        bit i_pend, d_pend, d_wr, s_data, s_wr;
        logic [3:0] i_idx, d_idx, d_strb, s_idx, s_strb;
        logic [DATA_W-1:0] d_wd, s_wd;
        int i_wait, d_wait, d_since_i, n_i_done, n_d_done;
        bit allow;
        i_pend = 0; d_pend = 0; s_data = 0; i_wait = 0; d_wait = 0; d_since_i = 0; n_i_done = 0; n_d_done = 0;
        i_idx = '0; d_idx = '0; d_strb = '0; d_wd = '0; d_wr = 0; s_idx = '0; s_strb = '0; s_wd = '0; s_wr = 0;
        for (int w = 0; w < 16; w++) begin ref_mem[w] = $urandom; slv_mem[w] = ref_mem[w]; end
        for (int cyc = 0; cyc < n_cycles + 300; cyc++) begin
            allow = (cyc < n_cycles);
            if (!allow && !i_pend && !d_pend && !s_data) break;
            if (allow && !i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_idx = 4'($urandom); i_wait = 0; d_since_i = 0;
            end
            if (allow && !d_pend && $urandom_range(0, 3) != 0) begin
                d_pend = 1; d_idx = 4'($urandom); d_wr = 1'($urandom); d_strb = 4'($urandom); d_wd = $urandom; d_wait = 0;
            end
            mif.inst_req = i_pend; mif.inst_addr = {26'b0, i_idx, 2'b00};
            mif.data_req = d_pend; mif.data_wr = d_wr; mif.data_wstrb = d_strb;
            mif.data_addr = {26'b0, d_idx, 2'b00}; mif.data_wdata = d_wd;
            mif.bus_addr_ok = 1'($urandom);
            if (s_data) begin
                mif.bus_data_ok = ($urandom_range(0, 2) != 0); mif.bus_rdata = slv_mem[s_idx];
            end else begin
                mif.bus_data_ok = ($urandom_range(0, 3) == 0); mif.bus_rdata = $urandom;
            end
            @(negedge clk);
            if (s_data && mif.bus_data_ok) begin
                if (s_wr) for (int b = 0; b < 4; b++) if (s_strb[b]) slv_mem[s_idx][8*b +: 8] = s_wd[8*b +: 8];
                s_data = 0;
            end else if (!s_data && mif.bus_req && mif.bus_addr_ok) begin
                s_data = 1; s_idx = mif.bus_addr[5:2]; s_wr = mif.bus_wr; s_strb = mif.bus_wstrb; s_wd = mif.bus_wdata;
            end
            if (mif.inst_ok && mif.data_ok) begin
                n_checks++; n_fail++; $display("FAIL rnd_dual_ok: both ok pulses at cycle %0d", cyc);
            end
            if (mif.inst_ok) begin
                n_checks++;
                if (!i_pend) begin n_fail++; $display("FAIL rnd_inst_ok_unexpected: cycle %0d", cyc); end
                else if (mif.inst_rdata !== ref_mem[i_idx]) begin n_fail++; $display("FAIL rnd_inst_rdata: word %0d got %h want %h", i_idx, mif.inst_rdata, ref_mem[i_idx]); end
                i_pend = 0; n_i_done++;
            end
            if (mif.data_ok) begin
                n_checks++;
                if (!d_pend) begin n_fail++; $display("FAIL rnd_data_ok_unexpected: cycle %0d", cyc); end
                else if (!d_wr && mif.data_rdata !== ref_mem[d_idx]) begin n_fail++; $display("FAIL rnd_data_rdata: word %0d got %h want %h", d_idx, mif.data_rdata, ref_mem[d_idx]); end
                if (d_pend && d_wr) for (int b = 0; b < 4; b++) if (d_strb[b]) ref_mem[d_idx][8*b +: 8] = d_wd[8*b +: 8];
                d_pend = 0; n_d_done++;
                if (i_pend) begin
                    d_since_i++;
                    n_checks++;
                    if (d_since_i > MAXS + 1) begin n_fail++; $display("FAIL rnd_streak_bound: got %0d data completions while fetch waits, limit %0d", d_since_i, MAXS + 1); end
                end
            end
            if (i_pend) i_wait++;
            if (d_pend) d_wait++;
            if (i_wait == 100) begin n_checks++; n_fail++; $display("FAIL rnd_inst_timeout: fetch waited 100 cycles"); end
            if (d_wait == 100) begin n_checks++; n_fail++; $display("FAIL rnd_data_timeout: data access waited 100 cycles"); end
            tick();
        end
        n_checks++; if (i_pend || d_pend || s_data) begin n_fail++; $display("FAIL rnd_drain: got pending i/d/s=%b%b%b want 000", i_pend, d_pend, s_data); end
        n_checks++; if (n_i_done == 0 || n_d_done == 0) begin n_fail++; $display("FAIL rnd_progress: got inst=%0d data=%0d completions want both >0", n_i_done, n_d_done); end
        clear_inputs();
        tick();
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_inst_read();
        test_data_write();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_spurious();
        test_random(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single SRAM-like memory bus between the instruction-fetch port (read only) and the data-memory port (read/write).
- Sequences each access through separate address and data phases.
- Returns read data to the winning port and drives the if_stall / mem_stall inputs of the pipeline stall controller.
- Data port has priority (older instruction); a streak counter bounds instruction-fetch starvation.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; must be a multiple of 8
- MAX_DATA_STREAK, 4, max consecutive data grants while inst_req is pending; must be >= 1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- inst_req  in  1  fetch request; held until inst_ok
- inst_addr  in  ADDR_W  fetch address; stable while inst_req
- inst_rdata  out  DATA_W  fetch data; valid when inst_ok
- inst_ok  out  1  fetch completion, one cycle
- data_req  in  1  data request; held until data_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  DATA_W/8  byte enables (writes only)
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_rdata  out  DATA_W  read data; valid when data_ok
- data_ok  out  1  data completion, one cycle
- bus_req  out  1  address-phase request
- bus_wr  out  1  write flag
- bus_wstrb  out  DATA_W/8  byte enables
- bus_addr  out  ADDR_W  address
- bus_wdata  out  DATA_W  write data
- bus_addr_ok  in  1  address accepted
- bus_data_ok  in  1  data phase complete
- bus_rdata  in  DATA_W  read data, valid with bus_data_ok
- if_stall_o  out  1  inst_req & ~inst_ok
- mem_stall_o  out  1  data_req & ~data_ok

Behaviour:
- FSM states: IDLE, ADDR, DATA. Registered grant bit: 0 = inst, 1 = data.
- IDLE arbitration, evaluated every cycle:
  - data_req & (~inst_req | streak < MAX_DATA_STREAK): grant data.
  - else if inst_req: grant inst.
  - else stay in IDLE.
  - On any grant, next state is ADDR.
- ADDR:
  - bus_req = 1; bus_* driven combinationally from the granted port.
  - Inst grant: bus_wr = 0, bus_wstrb = 0, bus_wdata = 0.
  - Data read: bus_wstrb = 0.
  - bus_addr_ok = 1 moves the FSM to DATA.
  - bus_data_ok in ADDR is ignored.
- DATA:
  - bus_req = 0.
  - bus_data_ok = 1 in the same cycle: granted port's *_ok = 1, *_rdata = bus_rdata (combinational; write completions also pulse ok), next state IDLE.
- Outside DATA & bus_data_ok: inst_ok = data_ok = 0 and both rdata outputs = 0.
- Minimum latency: request seen in IDLE at cycle 0, addr_ok in cycle 1, data_ok in cycle 2, ok in cycle 2. Back-to-back accesses cost 3 cycles each.
- A requester drops or changes its request in the cycle after its ok. The arbiter never grants in the same cycle it signals ok, because the FSM is not in IDLE then.
- Streak counter, width clog2(MAX_DATA_STREAK+1):
  - Data grant with inst_req = 1: increment, saturating at MAX_DATA_STREAK.
  - Data grant with inst_req = 0: clear.
  - Inst grant: clear.
- Simultaneous requests in IDLE: data wins unless streak == MAX_DATA_STREAK.
- bus_addr_ok outside ADDR and bus_data_ok outside DATA: ignored.
- Request deassertion mid-transaction is illegal; the arbiter completes the transaction regardless.
- Reset (rst == 0 at posedge), including mid-transaction:
  - state = IDLE, grant = 0, streak = 0.
  - All bus_* outputs, *_ok and *_rdata are 0.
  - The in-flight bus transaction is abandoned; the slave shares rst.
- Stall outputs are purely combinational. During reset they follow the requests and are gated only by *_ok.

Test Plan:
- Inst-only read: inst_req = 1, addr 0x0000_0100; slave gives addr_ok at cycle 1 and data_ok + rdata 0xDEAD_BEEF at cycle 2 -> inst_ok pulses at cycle 2 with inst_rdata 0xDEAD_BEEF; if_stall_o = 1 in cycles 0-1 and 0 in cycle 2.
- Data write: data_wr = 1, wstrb 4'b0011, addr 0x80, wdata 0x1234_5678; addr_ok delayed 3 cycles -> bus fields stable with bus_req = 1 for 3 cycles; data_ok pulses on bus_data_ok; inst_ok stays 0.
- Simultaneous inst and data requests -> data granted first, inst granted in the following IDLE; mem_stall_o drops before if_stall_o.
- Starvation bound: inst_req held while data_req is re-raised after each data_ok, MAX_DATA_STREAK = 4 -> exactly 4 data grants, then inst granted; streak reads 0 afterwards.
- Reset asserted in DATA state before bus_data_ok -> next cycle state IDLE, bus_req = 0, no ok pulse; a post-reset inst_req completes normally in 3 cycles.
- Spurious bus_data_ok in IDLE and in ADDR -> no ok pulses and no state change.
